// File: rtl/restoring_divider_pkg.sv
// Shared width, FSM state type and hex-to-seven-segment glyph table
// for the restoring divider board block.
package restoring_divider_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Active-low glyph, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] glyph;
    case (hex)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/restoring_divider_final_seven_seg_mux8.sv
// Eight-digit multiplexed seven-segment driver: scans digits 0..7, holding
// each for REFRESH_CYCLES clocks, and shows the matching nibble of value.
module seven_seg_mux8
  import restoring_divider_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [6:0]  seg,
  output logic [7:0]  an
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [2:0]    digit_q, digit_d;
  logic [3:0]    nibble;

  always_comb begin
    refresh_d = refresh_q + CW'(1);
    digit_d   = digit_q;
    if (refresh_q == CW'(REFRESH_CYCLES - 1)) begin
      refresh_d = '0;
      digit_d   = digit_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
    end
  end

  assign nibble = 4'(value >> {digit_q, 2'b00});
  assign seg    = hex_to_seg(nibble);
  assign an     = ~(8'b1 << digit_q);

endmodule

// File: rtl/restoring_divider_final.sv
// 16-bit unsigned restoring divider with push/toggle operand loading and an
// eight-digit display showing operands, or quotient/remainder when done.
module restoring_divider_final
  import restoring_divider_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             toggle,
  input  logic             push,
  input  logic [WIDTH-1:0] user_input,
  output logic             valid,
  output logic [6:0]       seg,
  output logic [7:0]       an
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] quotient, quotient_d;
  logic [WIDTH-1:0] remainder, remainder_d;
  logic             valid_q, valid_d;

  // A stays below the divisor, so only its low 16 bits need storing;
  // the 17-bit shifted value carries the extra bit into the trial subtract.
  logic [WIDTH:0]   a_sh, diff;
  logic [WIDTH-1:0] a_next, q_next;

  assign a_sh   = {a_q, q_q[WIDTH-1]};
  assign diff   = a_sh - {1'b0, divisor_q};
  assign a_next = diff[WIDTH] ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next = {q_q[WIDTH-2:0], ~diff[WIDTH]};

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    a_d         = a_q;
    q_d         = q_q;
    count_d     = count_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    valid_d     = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (push) begin
          if (toggle) divisor_d = user_input;
          else        dividend_d = user_input;
          if (state_q == DONE) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (start) begin
          if (divisor_q == '0) begin
            quotient_d  = '0;
            remainder_d = dividend_q;
            valid_d     = 1'b1;
            state_d     = DONE;
          end else begin
            a_d     = '0;
            q_d     = dividend_q;
            count_d = '0;
            valid_d = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        a_d     = a_next;
        q_d     = q_next;
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) begin
          quotient_d  = q_next;
          remainder_d = a_next;
          valid_d     = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      a_q        <= '0;
      q_q        <= '0;
      count_q    <= '0;
      quotient   <= '0;
      remainder  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      a_q        <= a_d;
      q_q        <= q_d;
      count_q    <= count_d;
      quotient   <= quotient_d;
      remainder  <= remainder_d;
      valid_q    <= valid_d;
    end
  end

  assign valid = valid_q;

  logic [31:0] disp_value;
  assign disp_value = (state_q == DONE) ? {quotient, remainder}
                                        : {dividend_q, divisor_q};

  seven_seg_mux8 #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_disp (
    .clk   (clk),
    .rst   (rst),
    .value (disp_value),
    .seg   (seg),
    .an    (an)
  );

endmodule

// File: tb/tb_restoring_divider_final.sv
// Directed bench for restoring_divider_final: operand loading, 17-edge
// latency, divide-by-zero, ignored BUSY inputs, mid-run reset and display.
module tb_restoring_divider_final;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        toggle = 1'b0;
  logic        push = 1'b0;
  logic [15:0] user_input = '0;
  logic        valid;
  logic [6:0]  seg;
  logic [7:0]  an;

  int total = 0;
  int bad = 0;

  restoring_divider_final #(.REFRESH_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .toggle     (toggle),
    .push       (push),
    .user_input (user_input),
    .valid      (valid),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic tog, input logic [15:0] val);
    toggle = tog;
    user_input = val;
    push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Start edge counts as edge 1; valid must be low after 16 edges, high after 17.
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] exp_q, input logic [15:0] exp_r);
    do_push(1'b0, dvd);
    do_push(1'b1, dvs);
    pulse_start();
    repeat (15) tick();
    chk({tag, "_valid_early"}, {31'b0, valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "_quot"}, {16'b0, dut.quotient}, {16'b0, exp_q});
    chk({tag, "_rem"}, {16'b0, dut.remainder}, {16'b0, exp_r});
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_quot", {16'b0, dut.quotient}, 32'd0);
    chk("rst_rem", {16'b0, dut.remainder}, 32'd0);
    chk("rst_an", {24'b0, an}, 32'h0000_00FE);
    chk("rst_seg", {25'b0, seg}, {25'b0, 7'b1000000});
    rst = 1'b1;
    tick();

    run_div("d25_3", 16'd25, 16'd3, 16'd8, 16'd1);
    for (int i = 0; i < 64 && an !== 8'hFE; i++) tick();
    chk("disp_an", {24'b0, an}, 32'h0000_00FE);
    chk("disp_seg", {25'b0, seg}, {25'b0, 7'b1111001});

    run_div("d100_10", 16'd100, 16'd10, 16'd10, 16'd0);
    run_div("d50_7", 16'd50, 16'd7, 16'd7, 16'd1);
    run_div("d12345_123", 16'd12345, 16'd123, 16'd100, 16'd45);
    run_div("d65535_1", 16'd65535, 16'd1, 16'd65535, 16'd0);
    run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0);

    do_push(1'b0, 16'd1234);
    do_push(1'b1, 16'd0);
    chk("dz_valid_pre", {31'b0, valid}, 32'd0);
    pulse_start();
    chk("dz_valid", {31'b0, valid}, 32'd1);
    chk("dz_quot", {16'b0, dut.quotient}, 32'd0);
    chk("dz_rem", {16'b0, dut.remainder}, 32'd1234);

    // Push and start during BUSY must both be ignored.
    do_push(1'b0, 16'd50);
    do_push(1'b1, 16'd7);
    pulse_start();
    repeat (2) tick();
    toggle = 1'b1;
    user_input = 16'd2;
    push = 1'b1;
    start = 1'b1;
    tick();
    push = 1'b0;
    start = 1'b0;
    repeat (12) tick();
    chk("busy_valid_early", {31'b0, valid}, 32'd0);
    tick();
    chk("busy_valid", {31'b0, valid}, 32'd1);
    chk("busy_quot", {16'b0, dut.quotient}, 32'd7);
    chk("busy_rem", {16'b0, dut.remainder}, 32'd1);
    do_push(1'b0, 16'd50);
    chk("push_clears_valid", {31'b0, valid}, 32'd0);

    // Reset during iteration 5 aborts the run.
    do_push(1'b0, 16'd12345);
    do_push(1'b1, 16'd123);
    pulse_start();
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_quot", {16'b0, dut.quotient}, 32'd0);
    chk("mid_rst_rem", {16'b0, dut.remainder}, 32'd0);
    chk("mid_rst_an", {24'b0, an}, 32'h0000_00FE);
    repeat (20) tick();
    chk("post_rst_idle", {31'b0, valid}, 32'd0);
    run_div("reload", 16'd12345, 16'd123, 16'd100, 16'd45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/restoring_divider_final.md
Name: restoring_divider_final

Overview:
16-bit unsigned restoring divider with a user load interface and an 8-digit multiplexed seven-segment display. The operator loads the dividend and divisor through a shared 16-bit input bus using push/toggle, then pulses start. The block computes one quotient bit per clock and raises valid when the quotient and remainder are ready. It is the top-level FPGA board block.

Parameters:
WIDTH, 16, operand, quotient and remainder width (fixed at 16; ports are sized to it).
REFRESH_CYCLES, 100000, clock cycles each display digit is held (set to 4 in simulation).

Ports:
clk  input  1  single system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  one-cycle pulse that begins a division.
toggle  input  1  load target select: 0 = dividend, 1 = divisor.
push  input  1  one-cycle pulse that latches user_input into the target selected by toggle.
user_input  input  16  operand value.
valid  output  1  high when the quotient and remainder are final.
seg  output  7  active-low segment cathodes; seg[0]=a … seg[6]=g.
an  output  8  active-low one-hot digit anodes; an[0] = rightmost digit.

Behaviour:
- Reset (rst==0 at a clock edge) clears: dividend, divisor, quotient, remainder, iteration counter, valid=0, state=IDLE, refresh counter, an=8'hFE, seg=7'b1000000 ("0").
- Internal registers named quotient[15:0] and remainder[15:0] hold the results. The bench reads them hierarchically.
- States: IDLE, BUSY, DONE.
- push in IDLE or DONE: on that edge, dividend (toggle=0) or divisor (toggle=1) ← user_input. In DONE, push also clears valid and moves to IDLE.
- start in IDLE or DONE (and push low):
  - Divisor==0: next edge sets quotient=0, remainder=dividend, valid=1, state=DONE.
  - Otherwise: next edge loads A=0 (17-bit), Q=dividend, counter=0, valid=0, state=BUSY.
- push and start in the same cycle: push wins; start is ignored.
- push or start while BUSY: ignored.
- BUSY iteration, one per clock:
  - {A,Q} shifted left 1.
  - T = A − {0,divisor}.
  - If T is negative (bit 16 = 1): A unchanged (restore) and Q[0]=0. Otherwise A=T and Q[0]=1.
- After the 16th iteration, on the same edge: quotient=Q, remainder=A[15:0], valid=1, state=DONE.
- Latency: valid rises on the 17th rising edge after the edge that sampled start (divide-by-zero: the 1st edge).
- valid stays high in DONE until reset, a push, or a new start (start clears valid on its accept edge).
- Results are unsigned: quotient = dividend / divisor and remainder = dividend % divisor. Operands 0 and 65535 are legal.
- Reset mid-operation aborts immediately. No partial results are retained.
- Display content:
  - State DONE: digits 7..4 show quotient hex, digits 3..0 show remainder hex.
  - Otherwise: digits 7..4 show dividend hex, digits 3..0 show divisor hex.
- Display scan: a refresh counter advances the active digit every REFRESH_CYCLES clocks, 0→7→0. an is a one-hot low at the active digit. seg is the hex glyph (0–F, active-low) of that digit's nibble.

Decomposition:
- Package restoring_divider_pkg holds:
  - WIDTH;
  - state enum {IDLE, BUSY, DONE};
  - function hex_to_seg(4-bit) → 7-bit active-low glyph (0=7'b1000000, 1=7'b1111001, … F=7'b0001110).
- One sub-module: seven_seg_mux8. Inputs: clk, rst, 32-bit value. Outputs: seg, an. It owns the refresh counter and digit select.
- The divider datapath and FSM stay in the top module.

Test Plan:
- Load 25 (toggle=0) and 3 (toggle=1), pulse start → valid after 17 edges; quotient=8, remainder=1. With an=8'hFE, seg=7'b1111001.
- 100/10 → 10 r0. 50/7 → 7 r1. 12345/123 → 100 r45. All with valid exactly 17 edges after start.
- 65535/1 → 65535 r0. 0/5 → 0 r0.
- 1234/0 → valid one edge after start; quotient=0, remainder=1234.
- During BUSY of 50/7, push toggle=1 value 2 and pulse start → both ignored; result still 7 r1. After valid, push clears valid.
- Assert rst=0 for one edge at iteration 5 of 12345/123 → valid=0, quotient=0, remainder=0, an=8'hFE. A reload of 12345/123 then completes as 100 r45.
